uart_rx_deframer: RTL and testbench

- Serial UART receiver feeding the debug unit's command/instruction-load path.
- Synchronises the asynchronous RX pin and detects start bits using 16x oversampling.
- Deframes 8N1 characters, LSB first, and presents each byte as a single-cycle ready pulse with the data held stable.
- Accepts a receiver-clear request from the debug unit (its rx-reset output).

---
 rtl/uart_rx_deframer_pkg.sv | 20 ++
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_rx_deframer.sv | 151 +++++++++++++++
 tb/tb_uart_rx_deframer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_deframer_pkg.sv
// Shared definitions for the debug-path UART: receiver FSM encoding, default
// oversampling factor and the ASCII command bytes the debug unit decodes.
package uart_rx_deframer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_START      = 3'd1,
    ST_DATA       = 3'd2,
    ST_STOP       = 3'd3,
    ST_BREAK_WAIT = 3'd4
  } rx_state_t;

  localparam int OVERSAMPLE_DEFAULT = 16;

  localparam logic [7:0] CMD_STEP     = 8'h73;  // 's'
  localparam logic [7:0] CMD_INSTR    = 8'h69;  // 'i'
  localparam logic [7:0] CMD_CONTINUE = 8'h63;  // 'c'
  localparam logic [7:0] CMD_RESET    = 8'h72;  // 'r'

endpackage

// File: rtl/uart_baud_tick.sv
// Sample-tick divider: one-clock tick every TICK_DIV clocks while enabled,
// held at phase zero while disabled so the next tick is a full period away.
module uart_baud_tick #(
  parameter int TICK_DIV = 10
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_enable,
  output logic o_tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] div_cnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      div_cnt <= '0;
    end else if (!i_enable || div_cnt == LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign o_tick = i_enable && (div_cnt == LAST);

endmodule

// File: rtl/uart_rx_deframer.sv
// 8N1 UART receiver with 16x oversampling; emits each byte as a single-cycle
// ready pulse and flags framing errors, waiting out line breaks.
module uart_rx_deframer
  import uart_rx_deframer_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
  parameter int TICK_DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_rx,
  input  logic                 i_rx_clear,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_ready,
  output logic                 o_rx_error,
  output logic                 o_busy
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [SW-1:0] MID_SAMPLE  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] LAST_SAMPLE = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT    = BW'(DATA_BITS - 1);

  logic                 rx_meta;
  logic                 rx_s;
  rx_state_t            state;
  logic [SW-1:0]        sample_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 tick;
  logic                 tick_enable;

  // Synchroniser idles high so reset never looks like a start bit.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  // Clear must zero the divider on the same edge it resets the FSM.
  assign tick_enable = (state != ST_IDLE) && !i_rx_clear;

  uart_baud_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_baud_tick (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_enable (tick_enable),
    .o_tick   (tick)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      sample_cnt <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      o_rx_data  <= '0;
      o_rx_ready <= 1'b0;
      o_rx_error <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      o_rx_ready <= 1'b0;
      o_rx_error <= 1'b0;
      if (i_rx_clear) begin
        state      <= ST_IDLE;
        sample_cnt <= '0;
        bit_cnt    <= '0;
        o_rx_data  <= '0;
        o_busy     <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (!rx_s) begin
              state      <= ST_START;
              sample_cnt <= '0;
              o_busy     <= 1'b1;
            end
          end
          ST_START: begin
            if (tick) begin
              if (sample_cnt == MID_SAMPLE) begin
                if (rx_s) begin
                  state  <= ST_IDLE;
                  o_busy <= 1'b0;
                end else begin
                  state      <= ST_DATA;
                  sample_cnt <= '0;
                  bit_cnt    <= '0;
                end
              end else begin
                sample_cnt <= sample_cnt + 1'b1;
              end
            end
          end
          ST_DATA: begin
            if (tick) begin
              if (sample_cnt == LAST_SAMPLE) begin
                sample_cnt <= '0;
                shift_reg  <= {rx_s, shift_reg[DATA_BITS-1:1]};
                bit_cnt    <= bit_cnt + 1'b1;
                if (bit_cnt == LAST_BIT) begin
                  state <= ST_STOP;
                end
              end else begin
                sample_cnt <= sample_cnt + 1'b1;
              end
            end
          end
          ST_STOP: begin
            if (tick) begin
              if (sample_cnt == LAST_SAMPLE) begin
                sample_cnt <= '0;
                if (rx_s) begin
                  o_rx_data  <= shift_reg;
                  o_rx_ready <= 1'b1;
                  state      <= ST_IDLE;
                  o_busy     <= 1'b0;
                end else begin
                  o_rx_error <= 1'b1;
                  state      <= ST_BREAK_WAIT;
                end
              end else begin
                sample_cnt <= sample_cnt + 1'b1;
              end
            end
          end
          ST_BREAK_WAIT: begin
            if (rx_s) begin
              state  <= ST_IDLE;
              o_busy <= 1'b0;
            end
          end
          default: begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer at 160 clocks per bit: table of frames
// plus hand-written glitch, framing-error, clear and reset sequences.
module tb_uart_rx_deframer;

  localparam int BIT_CLKS = 160;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_rx;
  logic       i_rx_clear;
  logic [7:0] o_rx_data;
  logic       o_rx_ready;
  logic       o_rx_error;
  logic       o_busy;

  int n_cmp  = 0;
  int n_fail = 0;

  int         ready_cnt  = 0;
  int         err_cnt    = 0;
  int         wide_cnt   = 0;
  logic       prev_ready = 1'b0;
  logic [7:0] rx_q[$];

  typedef struct {
    logic [7:0] data;
    int         gap;
    int         exp_ready;
    int         exp_err;
    logic [7:0] exp_data;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  uart_rx_deframer #(
    .DATA_BITS (8),
    .CLK_FREQ  (1_600_000),
    .BAUD_RATE (10_000)
  ) dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_rx       (i_rx),
    .i_rx_clear (i_rx_clear),
    .o_rx_data  (o_rx_data),
    .o_rx_ready (o_rx_ready),
    .o_rx_error (o_rx_error),
    .o_busy     (o_busy)
  );

  // Pulse monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (o_rx_ready) begin
      rx_q.push_back(o_rx_data);
      ready_cnt++;
      if (prev_ready) wide_cnt++;
    end
    prev_ready = o_rx_ready;
    if (o_rx_error) err_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  function automatic logic [31:0] last_byte();
    if (rx_q.size() == 0) return 32'hDEAD;
    return {24'h0, rx_q[rx_q.size()-1]};
  endfunction

  task automatic send_frame(input logic [7:0] data, input logic stop);
    logic [9:0] bits;
    bits = {stop, data, 1'b0};
    for (int b = 0; b < 10; b++) begin
      i_rx = bits[b];
      repeat (BIT_CLKS) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    i_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_and_check(input string name, input logic [7:0] data);
    int r0, e0;
    r0 = ready_cnt;
    e0 = err_cnt;
    send_frame(data, 1'b1);
    check({name, "_ready"}, ready_cnt - r0, 1);
    check({name, "_data"}, last_byte(), {24'h0, data});
    check({name, "_err"}, err_cnt - e0, 0);
  endtask

  task automatic wait_not_busy(input string name);
    int k;
    k = 0;
    while (o_busy && k < 4000) begin
      @(negedge clk);
      k++;
    end
    check({name, "_drain"}, o_busy, 0);
  endtask

  initial begin
    int r0, e0, k;

    vecs[0] = '{8'h73, 400, 1, 0, 8'h73, 1'b0};
    vecs[1] = '{8'h69, 0,   1, 0, 8'h69, 1'b0};
    vecs[2] = '{8'hA5, 0,   1, 0, 8'hA5, 1'b0};
    vecs[3] = '{8'h00, 0,   1, 0, 8'h00, 1'b0};
    vecs[4] = '{8'hFF, 200, 1, 0, 8'hFF, 1'b0};

    i_reset    = 1'b1;
    i_rx       = 1'b1;
    i_rx_clear = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_data", o_rx_data, 0);
    check("reset_ready", o_rx_ready, 0);
    check("reset_error", o_rx_error, 0);
    check("reset_busy", o_busy, 0);
    i_reset = 1'b0;
    idle(20);

    // Table: single frame followed by back-to-back frames with no gap.
    for (int v = 0; v < 5; v++) begin
      r0 = ready_cnt;
      e0 = err_cnt;
      send_frame(vecs[v].data, 1'b1);
      check($sformatf("vec%0d_ready", v), ready_cnt - r0, vecs[v].exp_ready);
      check($sformatf("vec%0d_data", v), last_byte(), {24'h0, vecs[v].exp_data});
      check($sformatf("vec%0d_err", v), err_cnt - e0, vecs[v].exp_err);
      check($sformatf("vec%0d_busy", v), o_busy, vecs[v].exp_busy);
      if (vecs[v].gap > 0) idle(vecs[v].gap);
    end

    // Short low glitch is rejected at the start-bit mid-sample.
    r0 = ready_cnt;
    e0 = err_cnt;
    i_rx = 1'b0;
    repeat (40) @(negedge clk);
    idle(300);
    check("glitch_ready", ready_cnt - r0, 0);
    check("glitch_err", err_cnt - e0, 0);
    check("glitch_busy", o_busy, 0);
    send_and_check("after_glitch_63", 8'h63);
    idle(100);

    // Framing error followed by a held-low break.
    r0 = ready_cnt;
    e0 = err_cnt;
    send_frame(8'h3C, 1'b0);
    repeat (2000) @(negedge clk);
    check("break_busy_low", o_busy, 1);
    idle(50);
    check("ferr_err", err_cnt - e0, 1);
    check("ferr_ready", ready_cnt - r0, 0);
    check("ferr_data_kept", o_rx_data, 8'h63);
    check("break_busy_after", o_busy, 0);
    send_and_check("after_ferr_3C", 8'h3C);
    idle(100);

    // Clear in the middle of data bit 4 of 0x55.
    r0 = ready_cnt;
    fork
      send_frame(8'h55, 1'b1);
      begin
        repeat (5 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
        i_rx_clear = 1'b1;
        @(negedge clk);
        i_rx_clear = 1'b0;
      end
    join
    check("clear_ready", ready_cnt - r0, 0);
    check("clear_data", o_rx_data, 0);
    // The low data bit 5 is a legitimate new start: it resyncs to 0xFD.
    wait_not_busy("clear_resync");
    idle(50);
    check("resync_ready", ready_cnt - r0, 1);
    check("resync_data", last_byte(), 32'hFD);
    send_and_check("after_clear_12", 8'h12);
    idle(100);

    // Async reset mid-frame, during a high data bit so no false start follows.
    fork
      send_frame(8'hF0, 1'b1);
      begin
        repeat (5 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
        check("pre_reset_busy", o_busy, 1);
        @(posedge clk);
        #2 i_reset = 1'b1;
        #1;
        check("async_reset_data", o_rx_data, 0);
        check("async_reset_busy", o_busy, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        i_reset = 1'b0;
      end
    join
    idle(100);
    send_and_check("after_reset_C3", 8'hC3);
    idle(100);

    // Clear on the cycle after a ready pulse: pulse stands, data zeroed.
    r0 = ready_cnt;
    fork
      send_frame(8'h5A, 1'b1);
      begin
        k = 0;
        while (!o_rx_ready && k < 3000) begin
          @(negedge clk);
          k++;
        end
        i_rx_clear = 1'b1;
        @(negedge clk);
        i_rx_clear = 1'b0;
      end
    join
    check("late_clear_ready", ready_cnt - r0, 1);
    check("late_clear_byte", last_byte(), 32'h5A);
    check("late_clear_data", o_rx_data, 0);

    check("ready_single_cycle", wide_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
